// File: rtl/sha_round_sequencer_if.sv
// rtl/sha_round_sequencer_if.sv - job/result handshakes and sha_unit drive bundle for sha_round_sequencer
// Optional feature macro: SHA_SEQ_ABORT_EN (adds the abort input)
interface sha_round_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] m_in;
  logic [255:0] h0_in;
  logic [511:0] sha_M;
  logic [255:0] sha_H0;
  logic [5:0]   sha_round;
  logic [31:0]  sha_Kt;
  logic [255:0] sha_H1;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] digest;
  logic         busy;
`ifdef SHA_SEQ_ABORT_EN
  logic         abort;
`endif

  // Sequencer side
  modport slave (
`ifdef SHA_SEQ_ABORT_EN
    input  abort,
`endif
    input  in_valid, m_in, h0_in, sha_H1, out_ready,
    output in_ready, sha_M, sha_H0, sha_round, sha_Kt, out_valid, digest, busy
  );

  // Job source, result consumer and sha_unit side
  modport master (
`ifdef SHA_SEQ_ABORT_EN
    output abort,
`endif
    output in_valid, m_in, h0_in, sha_H1, out_ready,
    input  in_ready, sha_M, sha_H0, sha_round, sha_Kt, out_valid, digest, busy
  );
endinterface

// File: rtl/sha_round_sequencer.sv
// rtl/sha_round_sequencer.sv - sequences one sha_unit through a full SHA-256 compression
// Optional feature macro: SHA_SEQ_ABORT_EN (abort input returns RUN/HOLD to IDLE)
module sha_round_sequencer #(
  parameter int K_LATCH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  sha_round_sequencer_if.slave     io
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]   state_q;
  logic [6:0]   c_q;
  logic [511:0] m_q;
  logic [255:0] h0_q;
  logic [255:0] digest_q;
  logic [31:0]  kt;

  logic in_fire;
  logic last_run;
  logic abort_hit;

  // SHA-256 round constants, FIPS 180-4
  function automatic logic [31:0] k_rom(input logic [5:0] a);
    case (a)
      6'd0:  k_rom = 32'h428a2f98;  6'd1:  k_rom = 32'h71374491;
      6'd2:  k_rom = 32'hb5c0fbcf;  6'd3:  k_rom = 32'he9b5dba5;
      6'd4:  k_rom = 32'h3956c25b;  6'd5:  k_rom = 32'h59f111f1;
      6'd6:  k_rom = 32'h923f82a4;  6'd7:  k_rom = 32'hab1c5ed5;
      6'd8:  k_rom = 32'hd807aa98;  6'd9:  k_rom = 32'h12835b01;
      6'd10: k_rom = 32'h243185be;  6'd11: k_rom = 32'h550c7dc3;
      6'd12: k_rom = 32'h72be5d74;  6'd13: k_rom = 32'h80deb1fe;
      6'd14: k_rom = 32'h9bdc06a7;  6'd15: k_rom = 32'hc19bf174;
      6'd16: k_rom = 32'he49b69c1;  6'd17: k_rom = 32'hefbe4786;
      6'd18: k_rom = 32'h0fc19dc6;  6'd19: k_rom = 32'h240ca1cc;
      6'd20: k_rom = 32'h2de92c6f;  6'd21: k_rom = 32'h4a7484aa;
      6'd22: k_rom = 32'h5cb0a9dc;  6'd23: k_rom = 32'h76f988da;
      6'd24: k_rom = 32'h983e5152;  6'd25: k_rom = 32'ha831c66d;
      6'd26: k_rom = 32'hb00327c8;  6'd27: k_rom = 32'hbf597fc7;
      6'd28: k_rom = 32'hc6e00bf3;  6'd29: k_rom = 32'hd5a79147;
      6'd30: k_rom = 32'h06ca6351;  6'd31: k_rom = 32'h14292967;
      6'd32: k_rom = 32'h27b70a85;  6'd33: k_rom = 32'h2e1b2138;
      6'd34: k_rom = 32'h4d2c6dfc;  6'd35: k_rom = 32'h53380d13;
      6'd36: k_rom = 32'h650a7354;  6'd37: k_rom = 32'h766a0abb;
      6'd38: k_rom = 32'h81c2c92e;  6'd39: k_rom = 32'h92722c85;
      6'd40: k_rom = 32'ha2bfe8a1;  6'd41: k_rom = 32'ha81a664b;
      6'd42: k_rom = 32'hc24b8b70;  6'd43: k_rom = 32'hc76c51a3;
      6'd44: k_rom = 32'hd192e819;  6'd45: k_rom = 32'hd6990624;
      6'd46: k_rom = 32'hf40e3585;  6'd47: k_rom = 32'h106aa070;
      6'd48: k_rom = 32'h19a4c116;  6'd49: k_rom = 32'h1e376c08;
      6'd50: k_rom = 32'h2748774c;  6'd51: k_rom = 32'h34b0bcb5;
      6'd52: k_rom = 32'h391c0cb3;  6'd53: k_rom = 32'h4ed8aa4a;
      6'd54: k_rom = 32'h5b9cca4f;  6'd55: k_rom = 32'h682e6ff3;
      6'd56: k_rom = 32'h748f82ee;  6'd57: k_rom = 32'h78a5636f;
      6'd58: k_rom = 32'h84c87814;  6'd59: k_rom = 32'h8cc70208;
      6'd60: k_rom = 32'h90befffa;  6'd61: k_rom = 32'ha4506ceb;
      6'd62: k_rom = 32'hbef9a3f7;  default: k_rom = 32'hc67178f2;
    endcase
  endfunction

  assign in_fire  = io.in_valid && (state_q == S_IDLE);
  assign last_run = (state_q == S_RUN) && (c_q == 7'd64);

`ifdef SHA_SEQ_ABORT_EN
  // Abort only has an effect once a job has been taken
  assign abort_hit = io.abort && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Control FSM and RUN cycle counter; abort wins over every other transition
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      c_q     <= 7'd0;
    end else if (abort_hit) begin
      state_q <= S_IDLE;
      c_q     <= 7'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io.in_valid) begin
            state_q <= S_RUN;
            c_q     <= 7'd0;
          end
        end
        S_RUN: begin
          if (c_q == 7'd64) begin
            state_q <= S_HOLD;
            c_q     <= 7'd0;
          end else begin
            c_q <= c_q + 7'd1;
          end
        end
        S_HOLD: begin
          if (io.out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          c_q     <= 7'd0;
        end
      endcase
    end
  end

  // Job latch: sha_unit adds H0 into H1 combinationally, so M/H0 must not move until IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q  <= '0;
      h0_q <= '0;
    end else if (in_fire) begin
      m_q  <= io.m_in;
      h0_q <= io.h0_in;
    end
  end

  // Digest capture at the last RUN cycle; an abort in that same cycle suppresses it
  always_ff @(posedge clk) begin
    if (reset) begin
      digest_q <= '0;
    end else if (last_run && !abort_hit) begin
      digest_q <= io.sha_H1;
    end
  end

  // Kt lags the round index by one because sha_unit consumes round r one cycle after round=r
  generate
    if (K_LATCH != 0) begin : g_kt_reg
      logic [31:0] kt_q;
      // Read address c now so K[c-1] is already on the output during cycle c
      always_ff @(posedge clk) begin
        if (reset || abort_hit) begin
          kt_q <= '0;
        end else if ((state_q == S_RUN) && (c_q != 7'd64)) begin
          kt_q <= k_rom(c_q[5:0]);
        end else begin
          kt_q <= '0;
        end
      end
      assign kt = kt_q;
    end else begin : g_kt_comb
      // c[5:0]-1 wraps to 63 at c=64, which is the constant needed there
      assign kt = ((state_q == S_RUN) && (c_q != 7'd0)) ? k_rom(c_q[5:0] - 6'd1) : 32'h0;
    end
  endgenerate

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_HOLD);
  assign io.busy      = (state_q == S_RUN) || (state_q == S_HOLD);
  assign io.sha_round = (state_q == S_RUN) ? c_q[5:0] : 6'd0;
  assign io.sha_Kt    = kt;
  assign io.sha_M     = m_q;
  assign io.sha_H0    = h0_q;
  assign io.digest    = digest_q;

endmodule

// File: doc/sha_round_sequencer.md
# sha_round_sequencer

Controller that drives one `sha_unit` through a complete SHA-256 compression. It accepts a message block and chaining value over a valid/ready handshake and holds them stable for the datapath. It generates the round index and the round constant Kt for each cycle, captures `H1` into a digest register, and presents the digest over a second valid/ready handshake. It sits between the job source (nonce/work feeder) and `sha_unit`; one sequencer owns exactly one `sha_unit`.

## Interface
Parameters:
- `K_LATCH`, 1, when 1 Kt is registered from the ROM (costs nothing in latency; see Timing); when 0 Kt is combinational from the ROM.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `in_valid`  in  1  job offered
- `in_ready`  out  1  sequencer can accept a job (high only in IDLE)
- `m_in`  in  512  message block, word 0 in bits 511:480
- `h0_in`  in  256  chaining value, A in bits 255:224
- `sha_M`  out  512  latched block to `sha_unit.M`
- `sha_H0`  out  256  latched chaining value to `sha_unit.H0`
- `sha_round`  out  6  round index to `sha_unit.round`
- `sha_Kt`  out  32  round constant to `sha_unit.Kt`
- `sha_H1`  in  256  result from `sha_unit.H1`
- `out_valid`  out  1  `digest` holds a finished result
- `out_ready`  in  1  consumer takes the result
- `digest`  out  256  final hash (`sha_H1` captured)
- `busy`  out  1  high in RUN or HOLD
- `abort`  in  1  present only with `SHA_SEQ_ABORT_EN`

## Operation
- Internal 64×32 K ROM holds the FIPS 180-4 SHA-256 constants (K[0]=0x428a2f98 … K[63]=0xc67178f2).
- The 7-bit cycle counter `c` counts RUN cycles 0..64.
- States:
  - IDLE: `in_ready`=1. On `in_valid & in_ready`, latch `m_in`→`sha_M`, `h0_in`→`sha_H0`, clear `c`, go to RUN.
  - RUN: `sha_round` = `c[5:0]` for c≤63 and 0 at c=64. `sha_Kt` = K[c−1] for 1≤c≤64 and 0 at c=0. `c` increments each cycle. At c=64, `sha_H1` is registered into `digest` and the state goes to HOLD.
  - HOLD: `out_valid`=1. On `out_ready`, go to IDLE.
- `sha_M` and `sha_H0` are stable for the whole of RUN and HOLD, because `sha_unit` adds `H0` into `H1` combinationally.
- `digest` changes only at the c=64 capture. It persists through IDLE until the next capture.
- `in_ready` is 0 in RUN and HOLD. A job offered then is not accepted and must stay asserted by the source.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `sha_round`=0, `sha_Kt`=0, `c`=0, `digest`=0, `sha_M`=0, `sha_H0`=0.
- Reset asserted in any state returns to IDLE on the next edge. Any in-flight result is discarded (`digest` is cleared).

## Timing
- The handshake completes in cycle t. RUN occupies t+1 … t+65 (c=0..64). `out_valid` rises in t+66 with `digest` valid.
- With `out_ready` high in t+66, `in_ready` is high in t+67. Throughput is therefore one block per 67 cycles with no backpressure.
- Kt alignment: `sha_unit` registers `Wt` and `S0` off `round`, so the round-r computation happens in the cycle after `round`=r. This is why Kt lags by one (K[c−1]).
- With `K_LATCH`=1, the ROM is read at address `c` and registered. The result still presents K[c−1] in cycle c, with no extra latency.

## Configuration
- `SHA_SEQ_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort` high in RUN or HOLD → IDLE on the next edge. `out_valid` is 0 from that edge, and `digest` is unchanged from its previous value.
  - `abort` in IDLE is ignored.
  - If `abort` and `out_ready` are both high in HOLD, the result is abort (same next state, no difference visible).
- Not defined: no `abort` port; a started job always runs to HOLD.

## Test plan
- Block "abc": `m_in` = 0x61626380, then 14 zero words, then 0x00000018; `h0_in` = standard IV 6a09e667…5be0cd19. Expected: `out_valid` in t+66, `digest` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: `m_in` = 0x80000000 followed by zeros, standard IV. Expected: `digest` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid`. Expected: `out_valid` and `digest` stay stable, `in_ready`=0 throughout, and a second `in_valid` is not accepted until one cycle after `out_ready`.
- Back-to-back jobs with `in_valid` and `out_ready` held high. Expected: handshakes 67 cycles apart, both digests correct, and `sha_round` trace 0..63,0 per job.
- Reset at c=30. Expected: IDLE, `in_ready`=1, `out_valid`=0, `digest`=0 on the next edge. A following "abc" job produces the correct digest.
- With `SHA_SEQ_ABORT_EN`: `abort` at c=10. Expected: IDLE next edge, `digest` keeps its prior value, no `out_valid` pulse, and the next job is correct.
